// File: rtl/sc1_boot_loader.sv
// sc1_boot_loader: UART byte-stream loader for the sc1_soc instruction and
// data memories. Parses A5-framed commands, writes 32-bit words assembled
// little-endian from the stream, sequences the CPU reset and answers every
// framed command with a single ACK (0x06) or NAK (0x15) byte.
module sc1_boot_loader #(
  parameter int          WIDTH_D        = 32,
  parameter int          DEPTH_I        = 10,
  parameter int          DEPTH_D        = 10,
  parameter bit          BOOT_HALTED    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 32'd40000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               cpu_reset,
  output logic               mem_i_we,
  output logic [DEPTH_I-1:0] mem_i_addr,
  output logic               mem_d_we,
  output logic [DEPTH_D-1:0] mem_d_addr,
  output logic [WIDTH_D-1:0] mem_wdata,
  output logic               error
);

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_LOAD_I = 8'h01;
  localparam logic [7:0] CMD_LOAD_D = 8'h02;
  localparam logic [7:0] CMD_RUN    = 8'h03;
  localparam logic [7:0] CMD_HALT   = 8'h04;
  localparam logic [7:0] RESP_ACK   = 8'h06;
  localparam logic [7:0] RESP_NAK   = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1, S_DATA, S_SUM, S_RESP
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [31:0]         timer_reg;
  logic                timeout_hit;
  logic [7:0]          addr_lo_reg;
  logic [DEPTH_I-1:0]  addr_i_reg;
  logic [DEPTH_D-1:0]  addr_d_reg;
  logic [15:0]         cnt_reg;
  logic [1:0]          byte_cnt_reg;
  logic [23:0]         shift_bytes;
  logic [7:0]          sum_reg;
  logic                target_d_reg;
  logic                we_i_reg;
  logic                we_d_reg;
  logic [WIDTH_D-1:0]  wdata_reg;
  logic [7:0]          resp_reg;
  logic                cpu_reset_reg;
  logic                error_reg;
  logic                byte_taken;
  logic                word_done;

  // A timeout in the same cycle as a byte wins: the frame is already abandoned.
  assign timeout_hit = (state_reg != S_IDLE) && (state_reg != S_RESP) &&
                       (timer_reg == TIMEOUT_CYCLES);
  assign byte_taken  = rx_valid && !timeout_hit;
  assign word_done   = byte_taken && (state_reg == S_DATA) && (byte_cnt_reg == 2'd3);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode; every parsing state waits for a byte, RESP waits for the handshake.
  always_comb begin
    state_next = state_reg;
    if (timeout_hit) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (rx_valid && rx_data == SYNC_BYTE) state_next = S_CMD;
        S_CMD:   if (rx_valid) begin
                   if (rx_data == CMD_LOAD_I || rx_data == CMD_LOAD_D) state_next = S_ADDR0;
                   else                                                state_next = S_RESP;
                 end
        S_ADDR0: if (rx_valid) state_next = S_ADDR1;
        S_ADDR1: if (rx_valid) state_next = S_CNT0;
        S_CNT0:  if (rx_valid) state_next = S_CNT1;
        S_CNT1:  if (rx_valid) begin
                   if ({rx_data, cnt_reg[7:0]} == 16'd0) state_next = S_SUM;
                   else                                  state_next = S_DATA;
                 end
        S_DATA:  if (rx_valid && byte_cnt_reg == 2'd3 && cnt_reg == 16'd1) state_next = S_SUM;
        S_SUM:   if (rx_valid) state_next = S_RESP;
        S_RESP:  if (tx_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state: the response is offered for the whole RESP stay.
  always_comb begin
    tx_valid = (state_reg == S_RESP);
  end

  // Inter-byte timer; only runs while a frame is being parsed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer_reg <= '0;
    else if (rx_valid || timeout_hit || state_reg == S_IDLE || state_reg == S_RESP)
      timer_reg <= '0;
    else
      timer_reg <= timer_reg + 32'd1;
  end

  // Holding lanes for the first three bytes of each data word.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] lane_reg;
      // Capture this lane's byte when the byte counter points at it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          lane_reg <= '0;
        else if (byte_taken && state_reg == S_DATA && byte_cnt_reg == 2'(gi))
          lane_reg <= rx_data;
      end
      assign shift_bytes[gi*8 +: 8] = lane_reg;
    end
  endgenerate

  // Frame header, counters and running checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_lo_reg  <= '0;
      addr_i_reg   <= '0;
      addr_d_reg   <= '0;
      cnt_reg      <= '0;
      byte_cnt_reg <= '0;
      sum_reg      <= '0;
      target_d_reg <= 1'b0;
    end else begin
      // Address advances the cycle after the write strobe; it wraps at the memory depth.
      if (we_i_reg || we_d_reg) begin
        addr_i_reg <= addr_i_reg + 1'b1;
        addr_d_reg <= addr_d_reg + 1'b1;
      end
      if (byte_taken) begin
        case (state_reg)
          S_CMD: begin
            target_d_reg <= (rx_data == CMD_LOAD_D);
            sum_reg      <= rx_data;
          end
          S_ADDR0: begin
            addr_lo_reg <= rx_data;
            sum_reg     <= sum_reg + rx_data;
          end
          S_ADDR1: begin
            addr_i_reg <= DEPTH_I'({rx_data, addr_lo_reg});
            addr_d_reg <= DEPTH_D'({rx_data, addr_lo_reg});
            sum_reg    <= sum_reg + rx_data;
          end
          S_CNT0: begin
            cnt_reg <= {8'h00, rx_data};
            sum_reg <= sum_reg + rx_data;
          end
          S_CNT1: begin
            cnt_reg[15:8] <= rx_data;
            byte_cnt_reg  <= 2'd0;
            sum_reg       <= sum_reg + rx_data;
          end
          S_DATA: begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            sum_reg      <= sum_reg + rx_data;
            if (byte_cnt_reg == 2'd3) cnt_reg <= cnt_reg - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // One-cycle write strobe to the selected memory with the assembled word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_i_reg  <= 1'b0;
      we_d_reg  <= 1'b0;
      wdata_reg <= '0;
    end else begin
      we_i_reg <= word_done && !target_d_reg;
      we_d_reg <= word_done && target_d_reg;
      if (word_done) wdata_reg <= {rx_data, shift_bytes};
    end
  end

  // CPU reset control, sticky error flag and the pending response byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset_reg <= BOOT_HALTED;
      error_reg     <= 1'b0;
      resp_reg      <= '0;
    end else if (timeout_hit) begin
      error_reg <= 1'b1;
    end else if (rx_valid) begin
      case (state_reg)
        S_IDLE: if (rx_data == SYNC_BYTE) error_reg <= 1'b0;
        S_CMD: begin
          if (rx_data == CMD_RUN) begin
            cpu_reset_reg <= 1'b0;
            resp_reg      <= RESP_ACK;
          end else if (rx_data == CMD_HALT) begin
            cpu_reset_reg <= 1'b1;
            resp_reg      <= RESP_ACK;
          end else if (rx_data != CMD_LOAD_I && rx_data != CMD_LOAD_D) begin
            error_reg <= 1'b1;
            resp_reg  <= RESP_NAK;
          end
        end
        S_SUM: begin
          if (rx_data == sum_reg) begin
            resp_reg <= RESP_ACK;
          end else begin
            resp_reg  <= RESP_NAK;
            error_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data    = resp_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign error      = error_reg;
  assign mem_i_we   = we_i_reg;
  assign mem_d_we   = we_d_reg;
  assign mem_i_addr = addr_i_reg;
  assign mem_d_addr = addr_d_reg;
  assign mem_wdata  = wdata_reg;

endmodule
